// File: rtl/arisco_pkg.sv
// Shared RV32I decode constants and FSM state type for the ALU instruction unit.
package arisco_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

endpackage

// File: rtl/alu_instruction_unit_register_file.sv
// Architectural register file: two operand read ports, a debug read port and one write port.
module register_file #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] dbg_data,
  input  logic            wr_en,
  input  logic [4:0]      wr_addr,
  input  logic [XLEN-1:0] wr_data
);

  localparam int AW = $clog2(NUM_REGS);
  localparam logic [5:0] NREG = 6'(NUM_REGS);

  logic [XLEN-1:0] regs [NUM_REGS];

  // x0 and addresses beyond the implemented file read as zero.
  function automatic logic [XLEN-1:0] read_reg(input logic [4:0] addr);
    if (addr == 5'd0 || {1'b0, addr} >= NREG) return '0;
    return regs[addr[AW-1:0]];
  endfunction

  assign rs1_data = read_reg(rs1_addr);
  assign rs2_data = read_reg(rs2_addr);
  assign dbg_data = read_reg(dbg_addr);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_en && wr_addr != 5'd0 && {1'b0, wr_addr} < NREG) begin
      regs[wr_addr[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/alu_instruction_unit.sv
// Three-cycle RV32I integer executor: accept, decode/compute, write back one instruction at a time.
module alu_instruction_unit
  import arisco_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int NUM_REGS  = 32,
  parameter bit ENABLE_OP = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [31:0]     instr,
  output logic            retire_valid,
  output logic [4:0]      retire_rd,
  output logic [XLEN-1:0] retire_data,
  output logic            illegal,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  localparam logic [5:0] NREG = 6'(NUM_REGS);

  state_t state, state_next;
  logic [31:0] instr_q;
  logic [XLEN-1:0] result_q;
  logic illegal_q;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rd, rs1, rs2, shamt;
  logic [XLEN-1:0] op_a, rs2_data, op_b, imm, alu_out, result;
  logic bad;

  assign opcode = instr_q[6:0];
  assign rd     = instr_q[11:7];
  assign funct3 = instr_q[14:12];
  assign rs1    = instr_q[19:15];
  assign rs2    = instr_q[24:20];
  assign funct7 = instr_q[31:25];
  assign imm    = {{(XLEN-12){instr_q[31]}}, instr_q[31:20]};
  assign op_b   = (opcode == OPC_OP) ? rs2_data : imm;
  assign shamt  = (opcode == OPC_OP) ? rs2_data[4:0] : instr_q[24:20];

  function automatic logic reg_ok(input logic [4:0] addr);
    return {1'b0, addr} < NREG;
  endfunction

  register_file #(.XLEN(XLEN), .NUM_REGS(NUM_REGS)) u_regs (
    .clk      (clk),
    .rst      (rst),
    .rs1_addr (rs1),
    .rs2_addr (rs2),
    .dbg_addr (dbg_addr),
    .rs1_data (op_a),
    .rs2_data (rs2_data),
    .dbg_data (dbg_data),
    .wr_en    (state == WB && !illegal_q),
    .wr_addr  (instr_q[11:7]),
    .wr_data  (result_q)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (instr_valid) state_next = EXEC;
      EXEC:    state_next = WB;
      WB:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    instr_ready  = (state == IDLE);
    retire_valid = (state == WB) && !illegal_q;
    illegal      = (state == WB) && illegal_q;
    retire_rd    = retire_valid ? instr_q[11:7] : 5'd0;
    retire_data  = retire_valid ? result_q : '0;
  end

  // funct7 bit 30 only selects SUB for OP; for OP-IMM those bits belong to the immediate.
  always_comb begin
    alu_out = '0;
    case (funct3)
      F3_ADD:  alu_out = (opcode == OPC_OP && funct7 == F7_ALT) ? op_a - op_b : op_a + op_b;
      F3_SLL:  alu_out = op_a << shamt;
      F3_SLT:  alu_out = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      F3_SLTU: alu_out = {{(XLEN-1){1'b0}}, op_a < op_b};
      F3_XOR:  alu_out = op_a ^ op_b;
      F3_SRL:  alu_out = (funct7 == F7_ALT) ? XLEN'($signed(op_a) >>> shamt) : op_a >> shamt;
      F3_OR:   alu_out = op_a | op_b;
      F3_AND:  alu_out = op_a & op_b;
      default: alu_out = '0;
    endcase
    result = (opcode == OPC_LUI) ? {instr_q[31:12], 12'b0} : alu_out;
  end

  always_comb begin
    bad = 1'b0;
    case (opcode)
      OPC_LUI:    bad = !reg_ok(rd);
      OPC_OP_IMM: bad = !reg_ok(rd) || !reg_ok(rs1)
                     || (funct3 == F3_SLL && funct7 != F7_BASE)
                     || (funct3 == F3_SRL && funct7 != F7_BASE && funct7 != F7_ALT);
      OPC_OP:     bad = !ENABLE_OP || !reg_ok(rd) || !reg_ok(rs1) || !reg_ok(rs2)
                     || !(funct7 == F7_BASE
                          || (funct7 == F7_ALT && (funct3 == F3_ADD || funct3 == F3_SRL)));
      default:    bad = 1'b1;
    endcase
  end

  // Latch the instruction at the handshake and the outcome at the end of EXEC.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q   <= '0;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      if (state == IDLE && instr_valid) instr_q <= instr;
      if (state == EXEC) begin
        result_q  <= bad ? '0 : result;
        illegal_q <= bad;
      end
    end
  end

endmodule

// File: tb/tb_alu_instruction_unit.sv
// Directed vector bench for alu_instruction_unit: a full RV32I instance and an RV32E instance without OP.
module tb_alu_instruction_unit;

  typedef struct {
    int          which;
    logic [31:0] ins;
    logic        exp_rv;
    logic        exp_ill;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
    logic [4:0]  dbg_addr;
    logic [31:0] exp_dbg;
  } vec_t;

  localparam int NV = 24;

  logic clk = 1'b0;
  logic rst;

  logic        valid_a, ready_a, rv_a, ill_a;
  logic [31:0] instr_a, data_a, dbgd_a;
  logic [4:0]  rd_a, dbga_a;
  logic        valid_b, ready_b, rv_b, ill_b;
  logic [31:0] instr_b, data_b, dbgd_b;
  logic [4:0]  rd_b, dbga_b;

  int num_vec = 0;
  int num_fail = 0;
  int acc_a = 0, done_a = 0, acc_b = 0, done_b = 0;

  logic [2:0]  cap_exec;
  logic        cap_rv, cap_ill;
  logic [4:0]  cap_rd;
  logic [31:0] cap_data, cap_dbg;

  vec_t vecs [NV];

  always #5 clk = ~clk;

  alu_instruction_unit #(.XLEN(32), .NUM_REGS(32), .ENABLE_OP(1'b1)) dut_a (
    .clk(clk), .rst(rst), .instr_valid(valid_a), .instr_ready(ready_a), .instr(instr_a),
    .retire_valid(rv_a), .retire_rd(rd_a), .retire_data(data_a), .illegal(ill_a),
    .dbg_addr(dbga_a), .dbg_data(dbgd_a)
  );

  alu_instruction_unit #(.XLEN(32), .NUM_REGS(16), .ENABLE_OP(1'b0)) dut_b (
    .clk(clk), .rst(rst), .instr_valid(valid_b), .instr_ready(ready_b), .instr(instr_b),
    .retire_valid(rv_b), .retire_rd(rd_b), .retire_data(data_b), .illegal(ill_b),
    .dbg_addr(dbga_b), .dbg_data(dbgd_b)
  );

  // Counts handshakes and completions per instance to catch double accepts or lost retires.
  always @(posedge clk) begin
    if (!rst) begin
      if (valid_a && ready_a) acc_a++;
      if (rv_a || ill_a) done_a++;
      if (valid_b && ready_b) acc_b++;
      if (rv_b || ill_b) done_b++;
    end
  end

  task automatic checkOutput(input string name, input int idx, input logic [31:0] act,
                             input logic [31:0] exp);
    num_vec++;
    if (act !== exp) begin
      num_fail++;
      $display("[TB] FAIL %s (vec %0d): got 0x%08h, expected 0x%08h", name, idx, act, exp);
    end
  endtask

  // Issues one instruction, holding valid through EXEC and WB, and captures what each phase shows.
  task automatic applyStimulus(input int which, input logic [31:0] ins, input logic [4:0] daddr);
    @(negedge clk);
    if (which == 0) begin valid_a = 1'b1; instr_a = ins; dbga_a = daddr; end
    else            begin valid_b = 1'b1; instr_b = ins; dbga_b = daddr; end
    @(negedge clk);
    cap_exec = (which == 0) ? {ready_a, rv_a, ill_a} : {ready_b, rv_b, ill_b};
    @(negedge clk);
    cap_rv   = (which == 0) ? rv_a   : rv_b;
    cap_ill  = (which == 0) ? ill_a  : ill_b;
    cap_rd   = (which == 0) ? rd_a   : rd_b;
    cap_data = (which == 0) ? data_a : data_b;
    @(negedge clk);
    cap_dbg  = (which == 0) ? dbgd_a : dbgd_b;
    valid_a = 1'b0;
    valid_b = 1'b0;
  endtask

  initial begin
    int exp_acc_a, exp_done_a, exp_acc_b;
    int dn;

    vecs[0]  = '{0, 32'h00500093, 1'b1, 1'b0, 5'd1,  32'h00000005, 5'd1,  32'h00000005};
    vecs[1]  = '{0, 32'hFFF00113, 1'b1, 1'b0, 5'd2,  32'hFFFFFFFF, 5'd2,  32'hFFFFFFFF};
    vecs[2]  = '{0, 32'h00415193, 1'b1, 1'b0, 5'd3,  32'h0FFFFFFF, 5'd3,  32'h0FFFFFFF};
    vecs[3]  = '{0, 32'h40415213, 1'b1, 1'b0, 5'd4,  32'hFFFFFFFF, 5'd4,  32'hFFFFFFFF};
    vecs[4]  = '{0, 32'h800002B7, 1'b1, 1'b0, 5'd5,  32'h80000000, 5'd5,  32'h80000000};
    vecs[5]  = '{0, 32'h0012A333, 1'b1, 1'b0, 5'd6,  32'h00000001, 5'd6,  32'h00000001};
    vecs[6]  = '{0, 32'h0012B3B3, 1'b1, 1'b0, 5'd7,  32'h00000000, 5'd7,  32'h00000000};
    vecs[7]  = '{0, 32'h40108433, 1'b1, 1'b0, 5'd8,  32'h00000000, 5'd8,  32'h00000000};
    vecs[8]  = '{0, 32'h00700013, 1'b1, 1'b0, 5'd0,  32'h00000007, 5'd0,  32'h00000000};
    vecs[9]  = '{0, 32'h0000057F, 1'b0, 1'b1, 5'd0,  32'h00000000, 5'd10, 32'h00000000};
    vecs[10] = '{0, 32'h002084B3, 1'b1, 1'b0, 5'd9,  32'h00000004, 5'd9,  32'h00000004};
    vecs[11] = '{0, 32'h0F014513, 1'b1, 1'b0, 5'd10, 32'hFFFFFF0F, 5'd10, 32'hFFFFFF0F};
    vecs[12] = '{0, 32'h01F09593, 1'b1, 1'b0, 5'd11, 32'h80000000, 5'd11, 32'h80000000};
    vecs[13] = '{0, 32'h41F09593, 1'b0, 1'b1, 5'd0,  32'h00000000, 5'd11, 32'h80000000};
    vecs[14] = '{0, 32'h4012D633, 1'b1, 1'b0, 5'd12, 32'hFC000000, 5'd12, 32'hFC000000};
    vecs[15] = '{0, 32'hFF017693, 1'b1, 1'b0, 5'd13, 32'hFFFFFFF0, 5'd13, 32'hFFFFFFF0};
    vecs[16] = '{0, 32'hFFF2A713, 1'b1, 1'b0, 5'd14, 32'h00000001, 5'd14, 32'h00000001};
    vecs[17] = '{0, 32'hFFF0B793, 1'b1, 1'b0, 5'd15, 32'h00000001, 5'd15, 32'h00000001};
    vecs[18] = '{0, 32'h00D0E833, 1'b1, 1'b0, 5'd16, 32'hFFFFFFF5, 5'd16, 32'hFFFFFFF5};
    vecs[19] = '{0, 32'h021088B3, 1'b0, 1'b1, 5'd0,  32'h00000000, 5'd17, 32'h00000000};
    vecs[20] = '{1, 32'h00100A13, 1'b0, 1'b1, 5'd0,  32'h00000000, 5'd20, 32'h00000000};
    vecs[21] = '{1, 32'h00300193, 1'b1, 1'b0, 5'd3,  32'h00000003, 5'd3,  32'h00000003};
    vecs[22] = '{1, 32'h00318233, 1'b0, 1'b1, 5'd0,  32'h00000000, 5'd4,  32'h00000000};
    vecs[23] = '{1, 32'h00188293, 1'b0, 1'b1, 5'd0,  32'h00000000, 5'd5,  32'h00000000};

    rst = 1'b1;
    valid_a = 1'b0; instr_a = '0; dbga_a = 5'd1;
    valid_b = 1'b0; instr_b = '0; dbga_b = 5'd3;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset ready",      -1, {31'b0, ready_a}, 32'd1);
    checkOutput("reset retire",     -1, {31'b0, rv_a},    32'd0);
    checkOutput("reset illegal",    -1, {31'b0, ill_a},   32'd0);
    checkOutput("reset retire_rd",  -1, {27'b0, rd_a},    32'd0);
    checkOutput("reset retire_dat", -1, data_a,           32'd0);
    checkOutput("reset dbg x1",     -1, dbgd_a,           32'd0);
    checkOutput("reset ready b",    -1, {31'b0, ready_b}, 32'd1);

    exp_acc_a = 0; exp_done_a = 0; exp_acc_b = 0;
    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i].which, vecs[i].ins, vecs[i].dbg_addr);
      if (vecs[i].which == 0) begin exp_acc_a++; exp_done_a++; end
      else exp_acc_b++;
      checkOutput("exec ready/retire/illegal", i, {29'b0, cap_exec}, 32'd0);
      checkOutput("retire_valid", i, {31'b0, cap_rv},  {31'b0, vecs[i].exp_rv});
      checkOutput("illegal",      i, {31'b0, cap_ill}, {31'b0, vecs[i].exp_ill});
      checkOutput("retire_rd",    i, {27'b0, cap_rd},  {27'b0, vecs[i].exp_rd});
      checkOutput("retire_data",  i, cap_data,         vecs[i].exp_data);
      checkOutput("dbg_data",     i, cap_dbg,          vecs[i].exp_dbg);
    end

    // Reset during EXEC of ADDI x9,x0,3 must abort the write and clear the file.
    @(negedge clk);
    valid_a = 1'b1; instr_a = 32'h00300493; dbga_a = 5'd9;
    exp_acc_a++;
    @(negedge clk);
    rst = 1'b1;
    valid_a = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort ready",   100, {31'b0, ready_a}, 32'd1);
    checkOutput("abort retire",  100, {31'b0, rv_a},    32'd0);
    checkOutput("abort illegal", 100, {31'b0, ill_a},   32'd0);
    checkOutput("abort dbg x9",  100, dbgd_a,           32'd0);
    dbga_a = 5'd1;
    #1;
    checkOutput("abort dbg x1 cleared", 100, dbgd_a, 32'd0);
    dn = done_a;
    repeat (3) @(negedge clk);
    checkOutput("abort no late retire", 100, done_a, dn);

    checkOutput("accepts a",     200, acc_a,  exp_acc_a);
    checkOutput("completions a", 200, done_a, exp_done_a);
    checkOutput("accepts b",     200, acc_b,  exp_acc_b);
    checkOutput("completions b", 200, done_b, exp_acc_b);

    $display("== %0d vectors applied, %0d miscompares ==", num_vec, num_fail);
    $finish;
  end

endmodule
